param_alu_ctrl: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 25 ++
 rtl/alu_exec_unit.sv | 96 +++++++++
 rtl/param_alu_ctrl.sv | 83 ++++++++
 tb/tb_param_alu_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the two-beat opcode ALU controller.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_PAR  = 3'd2,
    OP_COMP = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_MUL  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_B = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

endpackage

// File: rtl/alu_exec_unit.sv
// Operand registers, single-cycle op mux and a DATA_WIDTH-step shift-add multiplier.
// exec_done is combinational: high in the last EXEC cycle so the FSM leaves EXEC on that edge.
module alu_exec_unit import alu_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_a,
  input  logic                  load_b,
  input  logic                  start,
  input  op_t                   op,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  exec_done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  logic [W-1:0]   a_q, b_q;
  op_t            op_q;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           mul_run;

  logic [W-1:0]   alu_res;
  logic           alu_ovf;
  logic [W:0]     sum;

  logic [CW-1:0]  idx;
  logic [2*W-1:0] acc_base, partial, next_acc;
  logic           mul_step, mul_last;

  always_comb begin
    alu_res = '0;
    alu_ovf = OFF;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    case (op_q)
      OP_ADD:  begin alu_res = sum[W-1:0]; alu_ovf = sum[W]; end
      OP_SUB:  begin alu_res = a_q - b_q;  alu_ovf = (a_q < b_q); end
      OP_PAR:  alu_res[0] = ^{a_q, b_q};
      OP_COMP: alu_res[2:0] = {a_q < b_q, a_q > b_q, a_q == b_q};
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_res = '0;
    endcase
  end

  // The start cycle performs step 0 from a clean accumulator, so no stale product leaks in.
  always_comb begin
    idx      = start ? '0 : cnt;
    acc_base = start ? '0 : acc;
    partial  = b_q[idx] ? ({{W{1'b0}}, a_q} << idx) : '0;
    next_acc = acc_base + partial;
    mul_step = mul_run || (start && op_q == OP_MUL);
    mul_last = mul_run && (cnt == CW'(W - 1));
    exec_done = (op_q == OP_MUL) ? mul_last : start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      acc      <= '0;
      cnt      <= '0;
      mul_run  <= OFF;
      result   <= '0;
      overflow <= OFF;
    end else begin
      if (load_a) begin
        a_q  <= data;
        op_q <= op;
      end
      if (load_b) b_q <= data;
      if (start && op_q != OP_MUL) begin
        result   <= alu_res;
        overflow <= alu_ovf;
      end
      if (mul_step) begin
        acc <= next_acc;
        if (mul_last) begin
          mul_run  <= OFF;
          result   <= next_acc[W-1:0];
          overflow <= |next_acc[2*W-1:W];
        end else begin
          mul_run <= ON;
          cnt     <= idx + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/param_alu_ctrl.sv
// Two-beat handshake ALU controller: FSM, exec unit instance and output gating.
// result/overflow are forced to zero except during the one-cycle done pulse.
module param_alu_ctrl import alu_ctrl_pkg::*; #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    opcode_valid,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    overflow,
  output logic                    error
);

  state_t                state;
  logic                  load_a, load_b, start, exec_done;
  logic [DATA_WIDTH-1:0] exec_result;
  logic                  exec_overflow;

  assign load_a = (state == IDLE)  && opcode_valid;
  assign load_b = (state == GET_B) && opcode_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= OFF;
      done  <= OFF;
      error <= OFF;
      start <= OFF;
    end else begin
      done  <= OFF;
      error <= OFF;
      start <= OFF;
      case (state)
        IDLE: if (opcode_valid) begin
          state <= GET_B;
          busy  <= ON;
        end
        GET_B: if (opcode_valid) begin
          state <= EXEC;
          start <= ON;
        end else begin
          state <= IDLE;
          busy  <= OFF;
          error <= ON;
        end
        EXEC: if (exec_done) begin
          state <= DONE;
          done  <= ON;
        end
        DONE: begin
          state <= IDLE;
          busy  <= OFF;
        end
        default: begin
          state <= IDLE;
          busy  <= OFF;
        end
      endcase
    end
  end

  alu_exec_unit #(.DATA_WIDTH(DATA_WIDTH)) u_exec (
    .clk       (clk),
    .reset     (reset),
    .load_a    (load_a),
    .load_b    (load_b),
    .start     (start),
    .op        (op_t'(opcode)),
    .data      (data),
    .exec_done (exec_done),
    .result    (exec_result),
    .overflow  (exec_overflow)
  );

  assign result   = done ? exec_result : '0;
  assign overflow = done & exec_overflow;

endmodule

// File: tb/tb_param_alu_ctrl.sv
// Directed and randomized checks of param_alu_ctrl against an arithmetic reference model.
module tb_param_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         opcode_valid;
  logic [2:0]   opcode;
  logic [W-1:0] data;
  logic         busy, done, overflow, error;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  param_alu_ctrl #(.DATA_WIDTH(W), .OPCODE_WIDTH(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode_valid (opcode_valid),
    .opcode       (opcode),
    .data         (data),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .overflow     (overflow),
    .error        (error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: {overflow, result} straight from the opcode definitions.
  function automatic logic [8:0] ref_alu(input int op, input int a, input int b);
    int r;
    int o;
    r = 0;
    o = 0;
    case (op)
      0: begin r = (a + b) % 256; o = (a + b > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; o = (a < b) ? 1 : 0; end
      2: r = ($countones(a) + $countones(b)) % 2;
      3: r = ((a == b) ? 1 : 0) + ((a > b) ? 2 : 0) + ((a < b) ? 4 : 0);
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: begin r = (a * b) % 256; o = (a * b > 255) ? 1 : 0; end
    endcase
    return {o[0], r[7:0]};
  endfunction

  task automatic run_txn(input int op, input int a, input int b, input bit poke,
                         input int exp_res, input int exp_ovf, input string tag);
    int n;
    int lat;
    lat = (op == 7) ? 2 + W : 3;
    opcode_valid = 1'b1;
    opcode       = op[2:0];
    data         = a[7:0];
    tick();
    chk({tag, ".busy_b"}, busy, 1);
    data   = b[7:0];
    opcode = 3'($urandom_range(0, 7));
    tick();
    opcode_valid = poke;
    data         = 8'($urandom);
    n = 2;
    chk({tag, ".early_done"}, done, 0);
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
      opcode_valid = 1'b0;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".ovf"}, overflow, exp_ovf);
    chk({tag, ".err"}, error, 0);
    chk({tag, ".busy_done"}, busy, 1);
    tick();
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".res_gated"}, result, 0);
  endtask

  initial begin
    logic [8:0] m;
    int op, a, b;
    bit seen_done;

    reset = 1'b1;
    opcode_valid = 1'b0;
    opcode = '0;
    data = '0;
    tick();
    tick();
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.result", result, 0);
    chk("rst.ovf", overflow, 0);
    chk("rst.error", error, 0);
    reset = 1'b0;
    tick();

    run_txn(0, 8'hF0, 8'h20, 1'b0, 8'h10, 1, "add_wrap");
    run_txn(1, 8'h05, 8'h07, 1'b0, 8'hFE, 1, "sub_borrow");
    run_txn(1, 8'h07, 8'h05, 1'b0, 8'h02, 0, "sub_plain");
    run_txn(7, 8'h12, 8'h0F, 1'b0, 8'h0E, 1, "mul_ovf");
    run_txn(7, 8'h0F, 8'h0F, 1'b1, 8'hE1, 0, "mul_poke");
    run_txn(7, 8'h55, 8'h00, 1'b0, 8'h00, 0, "mul_zero");
    run_txn(3, 8'h33, 8'h33, 1'b0, 8'h01, 0, "comp_eq");
    run_txn(3, 8'h40, 8'h33, 1'b0, 8'h02, 0, "comp_gt");
    run_txn(3, 8'h10, 8'h33, 1'b1, 8'h04, 0, "comp_lt");
    run_txn(2, 8'h01, 8'h00, 1'b0, 8'h01, 0, "par");

    // Abort: beat 1 with no beat 2.
    opcode_valid = 1'b1;
    opcode = 3'd0;
    data = 8'hAA;
    tick();
    opcode_valid = 1'b0;
    tick();
    chk("abort.error", error, 1);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    tick();
    chk("abort.error_pulse", error, 0);
    run_txn(0, 8'h01, 8'h01, 1'b0, 8'h02, 0, "after_abort");

    // Reset in the middle of a MUL, with a stray beat during EXEC.
    seen_done = 1'b0;
    opcode_valid = 1'b1;
    opcode = 3'd7;
    data = 8'h12;
    tick();
    data = 8'h0F;
    tick();
    opcode = 3'd0;
    data = 8'h01;
    seen_done |= done;
    tick();
    opcode_valid = 1'b0;
    seen_done |= done;
    tick();
    chk("midmul.busy", busy, 1);
    seen_done |= done;
    tick();
    reset = 1'b1;
    seen_done |= done;
    tick();
    reset = 1'b0;
    chk("midmul.rst_busy", busy, 0);
    chk("midmul.rst_done", done, 0);
    chk("midmul.rst_result", result, 0);
    chk("midmul.rst_ovf", overflow, 0);
    chk("midmul.rst_error", error, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      seen_done |= done | error | busy;
    end
    chk("midmul.no_activity", seen_done, 0);

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) a = 255;
      if ($urandom_range(0, 4) == 0) b = ($urandom_range(0, 1) == 0) ? 0 : a;
      m = ref_alu(op, a, b);
      run_txn(op, a, b, 1'($urandom_range(0, 1)), int'(m[7:0]), int'(m[8]), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
